// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor with borrow-in and start/valid/ack handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  input  logic             iAck,
  output logic             oBusy,
  output logic             oValid,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B,
  output logic             oOvf,
  output logic             oZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt_q;

  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] res_n;
  logic             ovf_n;

  // Single full-subtractor cell; on the last shift d is the result MSB.
  always_comb begin
    d     = a_q[0] ^ b_q[0] ^ br_q;
    br_n  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_n = {d, res_q[WIDTH-1:1]};
    ovf_n = (a_msb ^ b_msb) & (d ^ a_msb);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt_q   <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oData_B <= 1'b0;
      oOvf    <= 1'b0;
      oZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            a_q   <= iData_a;
            b_q   <= iData_b;
            br_q  <= iB;
            a_msb <= iData_a[WIDTH-1];
            b_msb <= iData_b[WIDTH-1];
            cnt_q <= '0;
            oBusy <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_n;
          res_q <= res_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            oData   <= res_n;
            oData_B <= br_n;
            oOvf    <= ovf_n;
            oZero   <= (res_n == '0);
            oValid  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (iAck) begin
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 8;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iData_a = '0;
  logic [W-1:0] iData_b = '0;
  logic         iB = 1'b0;
  logic         iAck = 1'b0;
  logic         oBusy, oValid, oData_B, oOvf, oZero;
  logic [W-1:0] oData;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iData_a(iData_a),
    .iData_b(iData_b), .iB(iB), .iAck(iAck), .oBusy(oBusy), .oValid(oValid),
    .oData(oData), .oData_B(oData_B), .oOvf(oOvf), .oZero(oZero)
  );

  always #5 iClk = ~iClk;

  // Reference: {carry, sum} = a + ~b + ~bin, borrow = ~carry.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    exp_t       e;
    t = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
    e.d   = t[W-1:0];
    e.bo  = ~t[W];
    e.ovf = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
    e.z   = (t[W-1:0] == '0);
    sb.push_back(e);
    @(negedge iClk);
    iData_a = a; iData_b = b; iB = bin; iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0; iData_a = $urandom; iData_b = $urandom; iB = $urandom;
  endtask

  // Called at the negedge after the accepting edge; returns edges seen until oValid.
  task automatic wait_valid(output int n, output bit busy_drop);
    n = 0;
    busy_drop = 0;
    while (oValid !== 1'b1 && n < 20) begin
      if (oBusy !== 1'b1) busy_drop = 1;
      @(posedge iClk);
      n++;
      @(negedge iClk);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: result with empty scoreboard, got data=%h", name, oData);
    end else begin
      e = sb.pop_front();
      if ({oData, oData_B, oOvf, oZero} !== {e.d, e.bo, e.ovf, e.z}) begin
        errors++;
        $display("FAIL %s: got data=%h b=%b ovf=%b z=%b, expected data=%h b=%b ovf=%b z=%b",
                 name, oData, oData_B, oOvf, oZero, e.d, e.bo, e.ovf, e.z);
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int ack_delay, input string name);
    int n;
    bit bd;
    start_op(a, b, bin);
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, oBusy);
    end
    wait_valid(n, bd);
    checks++;
    if (n != W || bd) begin
      errors++;
      $display("FAIL %s latency: got %0d edges busy_drop=%0d, expected %0d edges busy_drop=0", name, n, bd, W);
    end
    check_result(name);
    repeat (ack_delay) @(negedge iClk);
    iAck = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iAck = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_ack: got valid=%b busy=%b expected 0 0", name, oValid, oBusy);
    end
  endtask

  task automatic test_reset;
    @(negedge iClk);
    checks++;
    if ({oBusy, oValid, oData, oData_B, oOvf, oZero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b data=%h b=%b ovf=%b z=%b expected all 0",
               oBusy, oValid, oData, oData_B, oOvf, oZero);
    end
    iRst_n = 1'b1;
  endtask

  task automatic test_directed;
    do_op(8'h05, 8'h03, 1'b0, 0, "sub_5_3");
    do_op(8'h00, 8'h01, 1'b0, 1, "sub_0_1");
    do_op(8'h80, 8'h01, 1'b0, 0, "sub_80_1");
    do_op(8'h10, 8'h0F, 1'b1, 2, "zero_borrowin");
    do_op(8'h80, 8'h00, 1'b1, 0, "ovf_borrowin");
  endtask

  task automatic test_hold_and_ignore;
    int n;
    bit bd;
    logic [W-1:0] d0;
    logic [3:0]   f0;
    bit           moved;
    start_op(8'h5A, 8'h21, 1'b0);
    repeat (2) @(negedge iClk);
    iStart = 1'b1; iData_a = 8'hFF; iData_b = 8'h00; iB = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    wait_valid(n, bd);
    checks++;
    if (n != W - 3) begin
      errors++;
      $display("FAIL hold latency: got %0d edges after mid-shift start, expected %0d", n, W - 3);
    end
    check_result("hold_result");
    d0 = oData;
    f0 = {oValid, oData_B, oOvf, oZero};
    moved = 0;
    for (int i = 0; i < 5; i++) begin
      iStart = 1'b1; iData_a = $urandom; iData_b = $urandom;
      @(negedge iClk);
      if (oData !== d0 || {oValid, oData_B, oOvf, oZero} !== f0) moved = 1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL hold_stable: got data=%h flags=%b, expected data=%h flags=%b",
               oData, {oValid, oData_B, oOvf, oZero}, d0, f0);
    end
    iAck = 1'b1; iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iAck = 1'b0; iStart = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== d0) begin
      errors++;
      $display("FAIL ack_with_start: got valid=%b busy=%b data=%h expected 0 0 %h", oValid, oBusy, oData, d0);
    end
    do_op(8'h33, 8'h44, 1'b1, 0, "after_ack_start");
  endtask

  task automatic test_reset_abort;
    bit rose;
    start_op(8'h09, 8'h02, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b0;
    #1;
    checks++;
    if ({oBusy, oValid, oData, oData_B, oOvf, oZero} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b valid=%b data=%h b=%b ovf=%b z=%b expected all 0",
               oBusy, oValid, oData, oData_B, oOvf, oZero);
    end
    rose = 0;
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge iClk);
      if (oValid !== 1'b0 || oBusy !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL abort_no_valid: valid or busy rose after aborted op, expected 0");
    end
    do_op(8'h7F, 8'h80, 1'b0, 0, "after_abort");
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold_and_ignore;
    test_reset_abort;
    test_random;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with borrow-in and a start/valid/ack handshake. It computes a − b − borrow_in one bit per clock, LSB first, and reports the borrow-out, signed overflow and zero flags. It is the subtract-direction counterpart of the combinational 8-bit adder in the arithmetic lab set, and it trades latency for a single full-subtractor cell. It is intended to sit behind the lab's switch and button front-end or a controller FSM.

## Interface
Parameters:
- WIDTH, 8, operand and result width (≥ 2)

Ports:
- iClk  input  1  system clock, all state on rising edge
- iRst_n  input  1  reset, asynchronous, active-low
- iStart  input  1  request; sampled only in IDLE
- iData_a  input  WIDTH  minuend, captured on accepted iStart
- iData_b  input  WIDTH  subtrahend, captured on accepted iStart
- iB  input  1  borrow-in, captured on accepted iStart
- iAck  input  1  result consumed; sampled only in DONE
- oBusy  output  1  high in SHIFT and DONE
- oValid  output  1  high in DONE only
- oData  output  WIDTH  difference (a − b − iB) mod 2^WIDTH
- oData_B  output  1  borrow-out: 1 iff unsigned a < b + iB
- oOvf  output  1  signed (two's-complement) overflow
- oZero  output  1  oData == 0

## Operation
- The state machine has three states: IDLE, SHIFT and DONE.
- IDLE:
  - On iStart = 1, capture iData_a, iData_b and iB into shift registers A, B and borrow register br.
  - Clear the bit counter and go to SHIFT.
- SHIFT, one bit per cycle:
  - d = A[0] ^ B[0] ^ br
  - br ← (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - d shifts into the result register from the MSB side; A and B shift right; the counter increments.
  - After the WIDTH-th SHIFT cycle, go to DONE.
- Entry to DONE registers the outputs together:
  - oData ← result
  - oData_B ← final br
  - oOvf ← (a[MSB] ≠ b[MSB]) & (oData[MSB] ≠ a[MSB]), using the captured operands
  - oZero ← (result == 0)
- DONE: oValid = 1 and all outputs are held stable. On iAck = 1, go to IDLE.
- Result outputs change only on entry to DONE. They keep their last value through IDLE and the next SHIFT.
- iStart outside IDLE is ignored. Operand inputs are don't-care except at the accepting edge.
- iAck outside DONE is ignored.
- iStart and iAck asserted together in DONE: the ack is taken and the start is ignored. A new request needs iStart in IDLE.
- Arithmetic is equivalent to {carry, sum} = a + ~b + ~iB, with oData_B = ~carry. A bench may use this as its reference model.

## Timing
- Reset (iRst_n low, asynchronous) sets:
  - state = IDLE, counter = 0, internal registers = 0
  - oBusy = 0, oValid = 0, oData = 0, oData_B = 0, oOvf = 0, oZero = 0
- Reset asserted mid-operation aborts the operation: no oValid and no partial result is exposed. Release is taken synchronously on the next rising edge with iRst_n high.
- Call the edge that accepts iStart edge 0:
  - oBusy is high after edge 0.
  - SHIFT occupies edges 1..WIDTH.
  - oValid and the results are high/valid after edge WIDTH. That is WIDTH cycles of latency: 8 for the default.
- oValid stays high indefinitely until iAck. After the edge that samples iAck = 1, oValid and oBusy are both 0.
- Minimum issue interval is WIDTH + 2 cycles: accept, WIDTH shifts, DONE with ack in the same cycle, then IDLE.
- There are no combinational paths from inputs to outputs.

## Test plan
- a=0x05, b=0x03, iB=0 → oData=0x02, oData_B=0, oOvf=0, oZero=0. oValid rises exactly 8 edges after the accepting edge; oBusy is high throughout.
- a=0x00, b=0x01, iB=0 → oData=0xFF, oData_B=1, oOvf=0. Then a=0x80, b=0x01 → oData=0x7F, oData_B=0, oOvf=1.
- a=0x10, b=0x0F, iB=1 → oData=0x00, oZero=1, oData_B=0. Then a=0x80, b=0x00, iB=1 → oData=0x7F, oOvf=1.
- Hold iAck low for 5 cycles in DONE → oValid and outputs stay stable. Pulse iStart with new operands during SHIFT and DONE → ignored and the result is unchanged. Assert iAck and iStart together → IDLE next cycle, then a new start is accepted.
- Drop iRst_n at SHIFT edge 4 → all outputs 0 immediately and oValid never rises. After release, a=0x7F, b=0x80, iB=0 → oData=0xFF, oData_B=1, oOvf=1.
- Run 1000 random operands with random iB and random ack delay 0–3 → every result matches (a + ~b + ~iB) mod 2^WIDTH, plus the flag equations above.
